branch_resolve: RTL and testbench
=================================

# branch_resolve

Pipelined, parametrised branch resolution stage for the RV32I core. It takes a decoded conditional branch with both register operands, evaluates the RV32I conditions selected by funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU), computes the target, and compares the outcome against the fetch-stage prediction. It sits between execute-operand select and the fetch redirect path, with a one-entry valid/ready pipeline register so it can be placed on a timing-critical boundary.

## Interface
- XLEN, 32: operand, PC and immediate width.
- CNT_W, 32: performance-counter width (used only with the counter feature).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the held result and any same-cycle input.
- in_valid  in  1  branch presented.
- in_ready  out  1  stage can accept.
- in_funct3  in  3  branch condition code.
- in_rs1, in_rs2  in  XLEN  operands.
- in_pc  in  XLEN  branch PC.
- in_imm  in  XLEN  sign-extended B-immediate.
- in_pred_taken  in  1  fetch prediction.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_taken  out  1  resolved direction.
- out_redirect_pc  out  XLEN  correct next PC.
- out_mispredict  out  1  direction mismatch vs prediction.
- out_illegal  out  1  funct3 is 010 or 011.
- out_misalign  out  1  taken target not 4-byte aligned.
- cnt_branches, cnt_mispredicts  out  CNT_W each  counters (feature-gated).

## Operation
- Accept when in_valid && in_ready && !flush; in_ready = !out_valid || out_ready.
- Conditions: 000 rs1==rs2; 001 !=; 100 signed <; 101 signed >=; 110 unsigned <; 111 unsigned >=.
- funct3 010/011: out_illegal=1, out_taken=0, out_mispredict=0, redirect = pc+4.
- Target = in_pc + in_imm, modulo 2^XLEN (carry discarded, wraps at top of address space). Fall-through = in_pc + 4, same wrap rule.
- out_redirect_pc = taken ? target : fall-through.
- out_mispredict = out_taken XOR in_pred_taken (legal funct3 only).
- out_misalign = out_taken && target[1:0] != 0; redirect still reports the target; trap handling is downstream.
- All outputs registered; result held stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle, input accept to out_valid.
- Throughput: 1 per cycle when out_ready held high (accept and drain in same cycle).
- Reset: out_valid=0, out_taken=0, out_redirect_pc=0, out_mispredict=0, out_illegal=0, out_misalign=0, counters=0; in_ready=1 the cycle after reset deasserts.
- flush: next cycle out_valid=0; same-cycle input dropped; flush overrides out_ready and in_valid.
- rst overrides flush.
- Data outputs are don't-care when out_valid=0 but must not change while out_valid && !out_ready.

## Configuration
- BRANCH_RESOLVE_PERF_EN defined: cnt_branches increments on each output handshake (out_valid && out_ready && !flush) of a legal branch; cnt_mispredicts increments when that handshake also has out_mispredict=1. Both saturate at 2^CNT_W-1; reset to 0.
- Not defined: counter registers absent, cnt_* ports tied to 0.

## Structure
- Shared package: funct3 constants (BEQ..BGEU) and the condition-evaluation function.
- Natural sub-module: branch_cond_eval (combinational, XLEN-parametrised, funct3 → taken/illegal) instantiated before the pipeline register.

## Test plan
- BEQ rs1=rs2=0x5, pc=0x100, imm=0x20, pred=0 → next cycle out_taken=1, redirect=0x120, mispredict=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken; BLTU same operands → not taken, redirect=pc+4.
- pc=0xFFFFFFF0, imm=0x20, BEQ taken → redirect=0x00000010 (wrap); imm=0x2 taken → out_misalign=1.
- funct3=010 → out_illegal=1, taken=0, redirect=pc+4, counters unchanged.
- Back-to-back 4 branches with out_ready=0 for 3 cycles → first result held stable, in_ready=0, no loss or duplication after release.
- flush with result held and new in_valid → out_valid=0 next cycle, counters unchanged; with PERF_EN and CNT_W=2, 5 mispredicted handshakes → cnt_mispredicts=3.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution stage: RV32I branch funct3
// codes and the condition-evaluation function used by branch_cond_eval.
package branch_resolve_pkg;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_RSV2 = 3'b010,
      F3_RSV3 = 3'b011,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } funct3_e;

   typedef struct packed {
      logic taken;
      logic illegal;
   } cond_res_t;

   // The width-dependent comparisons are done by the caller, so the package
   // stays independent of XLEN; this only selects among them by funct3.
   function automatic cond_res_t evalCond(input logic [2:0] funct3,
                                          input logic       eq,
                                          input logic       ltS,
                                          input logic       ltU);
      cond_res_t r;
      r = '0;
      case (funct3_e'(funct3))
         F3_BEQ:  r.taken = eq;
         F3_BNE:  r.taken = !eq;
         F3_BLT:  r.taken = ltS;
         F3_BGE:  r.taken = !ltS;
         F3_BLTU: r.taken = ltU;
         F3_BGEU: r.taken = !ltU;
         default: r.illegal = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational branch condition evaluator: compares the two operands at
// XLEN width and maps funct3 to a taken/illegal decision.
module branch_cond_eval
   import branch_resolve_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            taken,
   output logic            illegal
);

   logic      eq;
   logic      ltS;
   logic      ltU;
   cond_res_t res;

   // Operand comparisons and condition selection
   always_comb begin
      eq      = (rs1 == rs2);
      ltU     = (rs1 < rs2);
      ltS     = ($signed(rs1) < $signed(rs2));
      res     = evalCond(funct3, eq, ltS, ltU);
      taken   = res.taken;
      illegal = res.illegal;
   end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage with a one-entry valid/ready output register.
// Optional performance counters are enabled by defining BRANCH_RESOLVE_PERF_EN;
// without it cnt_branches / cnt_mispredicts are tied to zero.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_redirect_pc,
   output logic             out_mispredict,
   output logic             out_illegal,
   output logic             out_misalign,
   output logic [CNT_W-1:0] cnt_branches,
   output logic [CNT_W-1:0] cnt_mispredicts
);

   logic            condTaken;
   logic            condIllegal;
   logic            accept;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] fallThrough;
   logic [XLEN-1:0] nextRedirect;
   logic            nextMispredict;
   logic            nextMisalign;

   branch_cond_eval #(
      .XLEN (XLEN)
   ) uCond (
      .funct3  (in_funct3),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .taken   (condTaken),
      .illegal (condIllegal)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // Next-PC, misprediction and alignment results for the incoming branch
   always_comb begin
      target         = in_pc + in_imm;
      fallThrough    = in_pc + XLEN'(4);
      nextRedirect   = condTaken ? target : fallThrough;
      nextMispredict = !condIllegal && (condTaken ^ in_pred_taken);
      nextMisalign   = condTaken && (target[1:0] != 2'b00);
   end

   // Output register: load on accept, drop on drain or flush, hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid       <= 1'b0;
         out_taken       <= 1'b0;
         out_redirect_pc <= '0;
         out_mispredict  <= 1'b0;
         out_illegal     <= 1'b0;
         out_misalign    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid       <= 1'b1;
         out_taken       <= condTaken;
         out_redirect_pc <= nextRedirect;
         out_mispredict  <= nextMispredict;
         out_illegal     <= condIllegal;
         out_misalign    <= nextMisalign;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef BRANCH_RESOLVE_PERF_EN
   logic countHs;

   assign countHs = out_valid && out_ready && !flush && !out_illegal;

   // Saturating counters of resolved legal branches and mispredictions
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_branches    <= '0;
         cnt_mispredicts <= '0;
      end else if (countHs) begin
         if (cnt_branches != '1) begin
            cnt_branches <= cnt_branches + CNT_W'(1);
         end
         if (out_mispredict && (cnt_mispredicts != '1)) begin
            cnt_mispredicts <= cnt_mispredicts + CNT_W'(1);
         end
      end
   end
`else
   assign cnt_branches    = '0;
   assign cnt_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: scoreboard of expected results,
// compared against the output register every cycle it is valid.
module tb_branch_resolve;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;
`ifdef BRANCH_RESOLVE_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_funct3 = '0;
   logic [XLEN-1:0]  in_rs1 = '0;
   logic [XLEN-1:0]  in_rs2 = '0;
   logic [XLEN-1:0]  in_pc = '0;
   logic [XLEN-1:0]  in_imm = '0;
   logic             in_pred_taken = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_taken;
   logic [XLEN-1:0]  out_redirect_pc;
   logic             out_mispredict;
   logic             out_illegal;
   logic             out_misalign;
   logic [CNT_W-1:0] cnt_branches;
   logic [CNT_W-1:0] cnt_mispredicts;

   branch_resolve #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_funct3       (in_funct3),
      .in_rs1          (in_rs1),
      .in_rs2          (in_rs2),
      .in_pc           (in_pc),
      .in_imm          (in_imm),
      .in_pred_taken   (in_pred_taken),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_taken       (out_taken),
      .out_redirect_pc (out_redirect_pc),
      .out_mispredict  (out_mispredict),
      .out_illegal     (out_illegal),
      .out_misalign    (out_misalign),
      .cnt_branches    (cnt_branches),
      .cnt_mispredicts (cnt_mispredicts)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        v;
      bit [2:0]  f3;
      bit [31:0] rs1;
      bit [31:0] rs2;
      bit [31:0] pc;
      bit [31:0] imm;
      bit        pred;
      bit        ordy;
      bit        fl;
   } stim_t;

   typedef struct {
      bit        taken;
      bit [31:0] redirect;
      bit        mispredict;
      bit        illegal;
      bit        misalign;
   } exp_t;

   exp_t     sb[$];
   int       checks = 0;
   int       failures = 0;
   bit [1:0] modelBr = '0;
   bit [1:0] modelMis = '0;

   function automatic stim_t mk(bit v, bit [2:0] f3, bit [31:0] rs1, bit [31:0] rs2,
                                bit [31:0] pc, bit [31:0] imm, bit pred, bit ordy, bit fl);
      stim_t s;
      s.v = v; s.f3 = f3; s.rs1 = rs1; s.rs2 = rs2; s.pc = pc; s.imm = imm;
      s.pred = pred; s.ordy = ordy; s.fl = fl;
      return s;
   endfunction

   // Independent reference model of one resolved branch
   function automatic exp_t model(stim_t s);
      exp_t      e;
      bit        t;
      bit        ill;
      bit [31:0] tgt;
      ill = 1'b0;
      case (s.f3)
         3'd0:    t = (s.rs1 == s.rs2);
         3'd1:    t = (s.rs1 != s.rs2);
         3'd4:    t = ($signed(s.rs1) < $signed(s.rs2));
         3'd5:    t = ($signed(s.rs1) >= $signed(s.rs2));
         3'd6:    t = (s.rs1 < s.rs2);
         3'd7:    t = (s.rs1 >= s.rs2);
         default: begin t = 1'b0; ill = 1'b1; end
      endcase
      tgt          = s.pc + s.imm;
      e.taken      = t;
      e.redirect   = t ? tgt : (s.pc + 32'd4);
      e.mispredict = ill ? 1'b0 : (t ^ s.pred);
      e.illegal    = ill;
      e.misalign   = t && (tgt[1:0] != 2'b00);
      return e;
   endfunction

   task automatic apply(input stim_t s);
      in_valid      = s.v;
      in_funct3     = s.f3;
      in_rs1        = s.rs1;
      in_rs2        = s.rs2;
      in_pc         = s.pc;
      in_imm        = s.imm;
      in_pred_taken = s.pred;
      out_ready     = s.ordy;
      flush         = s.fl;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply(mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, out_taken, out_redirect_pc, out_mispredict, out_illegal, out_misalign} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v=%0b t=%0b pc=%h mp=%0b il=%0b ma=%0b exp all zero",
                  out_valid, out_taken, out_redirect_pc, out_mispredict, out_illegal, out_misalign);
      end
      checks++;
      if (cnt_branches !== '0 || cnt_mispredicts !== '0) begin
         failures++;
         $display("FAIL reset_counters got br=%0d mis=%0d exp 0 0", cnt_branches, cnt_mispredicts);
      end
      rst = 1'b0;
      sb.delete();
      modelBr = '0;
      modelMis = '0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
      end
   endtask

   task automatic test_directed();
      stim_t st[$];
      exp_t  e;
      st.push_back(mk(1, 3'b010, 1, 1, 32'h200, 32'h10, 1, 1, 0));
      st.push_back(mk(1, 3'b000, 5, 5, 32'h100, 32'h20, 0, 1, 0));
      st.push_back(mk(1, 3'b100, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 1, 1, 0));
      st.push_back(mk(1, 3'b110, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 1, 1, 0));
      st.push_back(mk(1, 3'b000, 9, 9, 32'hFFFF_FFF0, 32'h20, 1, 1, 0));
      st.push_back(mk(1, 3'b000, 9, 9, 32'hFFFF_FFF0, 32'h2, 1, 1, 0));
      st.push_back(mk(1, 3'b001, 7, 7, 32'h400, 32'h6, 0, 1, 0));
      st.push_back(mk(1, 3'b101, 32'h8000_0000, 3, 32'h500, 32'hFFFF_FFF0, 0, 1, 0));
      st.push_back(mk(1, 3'b111, 32'h8000_0000, 3, 32'h600, 32'h8, 0, 1, 0));
      st.push_back(mk(1, 3'b011, 2, 3, 32'h700, 32'h8, 0, 1, 0));
      for (int i = 0; i < 24; i++) begin
         bit [31:0] a;
         a = $urandom;
         st.push_back(mk($urandom_range(3) != 0, 3'($urandom_range(7)), a,
                         ($urandom_range(2) == 0) ? a : $urandom, $urandom,
                         $urandom & 32'hFFFF_FFFE, $urandom_range(1), $urandom_range(3) != 0, 0));
      end
      st.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0));
      st.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0));
      foreach (st[i]) begin
         @(negedge clk);
         apply(st[i]);
         #1;
         checks++;
         if (out_valid !== (sb.size() != 0)) begin
            failures++;
            $display("FAIL directed_valid cyc=%0d got=%0b exp=%0b", i, out_valid, sb.size() != 0);
         end
         checks++;
         if (cnt_branches !== (PERF_ON ? modelBr : 2'd0) || cnt_mispredicts !== (PERF_ON ? modelMis : 2'd0)) begin
            failures++;
            $display("FAIL directed_counters cyc=%0d got br=%0d mis=%0d exp br=%0d mis=%0d", i,
                     cnt_branches, cnt_mispredicts, PERF_ON ? modelBr : 2'd0, PERF_ON ? modelMis : 2'd0);
         end
         if (sb.size() != 0) begin
            e = sb[0];
            checks++;
            if (out_taken !== e.taken || out_redirect_pc !== e.redirect || out_mispredict !== e.mispredict ||
                out_illegal !== e.illegal || out_misalign !== e.misalign) begin
               failures++;
               $display("FAIL directed_result cyc=%0d got t=%0b pc=%h mp=%0b il=%0b ma=%0b exp t=%0b pc=%h mp=%0b il=%0b ma=%0b",
                        i, out_taken, out_redirect_pc, out_mispredict, out_illegal, out_misalign,
                        e.taken, e.redirect, e.mispredict, e.illegal, e.misalign);
            end
            if (out_ready && !flush) begin
               void'(sb.pop_front());
               if (!e.illegal) begin
                  if (modelBr != 2'd3) modelBr++;
                  if (e.mispredict && modelMis != 2'd3) modelMis++;
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(model(st[i]));
      end
   endtask

   task automatic test_back_to_back();
      stim_t b[4];
      stim_t s;
      exp_t  e;
      int    idx = 0;
      int    popped = 0;
      b[0] = mk(1, 3'b000, 3, 3, 32'h1000, 32'h40, 0, 0, 0);
      b[1] = mk(1, 3'b001, 3, 4, 32'h2000, 32'h80, 1, 0, 0);
      b[2] = mk(1, 3'b111, 1, 2, 32'h3000, 32'h10, 0, 0, 0);
      b[3] = mk(1, 3'b100, 5, 2, 32'h4000, 32'h20, 1, 0, 0);
      for (int cyc = 0; cyc < 12; cyc++) begin
         bit expRdy;
         s = (idx < 4) ? b[idx] : mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
         s.ordy = (cyc >= 4);
         @(negedge clk);
         apply(s);
         #1;
         expRdy = (sb.size() == 0) || s.ordy;
         checks++;
         if (in_ready !== expRdy) begin
            failures++;
            $display("FAIL b2b_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, expRdy);
         end
         checks++;
         if (out_valid !== (sb.size() != 0)) begin
            failures++;
            $display("FAIL b2b_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, sb.size() != 0);
         end
         if (sb.size() != 0) begin
            e = sb[0];
            checks++;
            if (out_taken !== e.taken || out_redirect_pc !== e.redirect || out_mispredict !== e.mispredict ||
                out_illegal !== e.illegal || out_misalign !== e.misalign) begin
               failures++;
               $display("FAIL b2b_result cyc=%0d got t=%0b pc=%h mp=%0b exp t=%0b pc=%h mp=%0b",
                        cyc, out_taken, out_redirect_pc, out_mispredict, e.taken, e.redirect, e.mispredict);
            end
            if (out_ready && !flush) begin
               void'(sb.pop_front());
               popped++;
               if (!e.illegal) begin
                  if (modelBr != 2'd3) modelBr++;
                  if (e.mispredict && modelMis != 2'd3) modelMis++;
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) begin
            sb.push_back(model(s));
            idx++;
         end
      end
      checks++;
      if (popped != 4 || idx != 4 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain got popped=%0d accepted=%0d out_valid=%0b exp 4 4 0", popped, idx, out_valid);
      end
   endtask

   task automatic test_flush();
      stim_t st[$];
      exp_t  e;
      st.push_back(mk(1, 3'b000, 8, 8, 32'h800, 32'h40, 0, 0, 0));
      st.push_back(mk(1, 3'b001, 8, 9, 32'h900, 32'h40, 0, 0, 0));
      st.push_back(mk(1, 3'b001, 8, 9, 32'h900, 32'h40, 0, 1, 1));
      st.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0));
      st.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0));
      foreach (st[i]) begin
         @(negedge clk);
         apply(st[i]);
         #1;
         checks++;
         if (out_valid !== (sb.size() != 0)) begin
            failures++;
            $display("FAIL flush_valid cyc=%0d got=%0b exp=%0b", i, out_valid, sb.size() != 0);
         end
         checks++;
         if (cnt_branches !== (PERF_ON ? modelBr : 2'd0) || cnt_mispredicts !== (PERF_ON ? modelMis : 2'd0)) begin
            failures++;
            $display("FAIL flush_counters cyc=%0d got br=%0d mis=%0d exp br=%0d mis=%0d", i,
                     cnt_branches, cnt_mispredicts, PERF_ON ? modelBr : 2'd0, PERF_ON ? modelMis : 2'd0);
         end
         if (sb.size() != 0) begin
            e = sb[0];
            checks++;
            if (out_taken !== e.taken || out_redirect_pc !== e.redirect || out_mispredict !== e.mispredict) begin
               failures++;
               $display("FAIL flush_result cyc=%0d got t=%0b pc=%h mp=%0b exp t=%0b pc=%h mp=%0b",
                        i, out_taken, out_redirect_pc, out_mispredict, e.taken, e.redirect, e.mispredict);
            end
            if (out_ready && !flush) begin
               void'(sb.pop_front());
               if (!e.illegal) begin
                  if (modelBr != 2'd3) modelBr++;
                  if (e.mispredict && modelMis != 2'd3) modelMis++;
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(model(st[i]));
      end
   endtask

   task automatic test_perf_saturation();
      stim_t st[$];
      exp_t  e;
      @(negedge clk);
      rst = 1'b1;
      apply(mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0));
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      modelBr = '0;
      modelMis = '0;
      for (int i = 0; i < 5; i++) st.push_back(mk(1, 3'b000, 7, 7, 32'h40 + 32'(i * 4), 32'h10, 0, 1, 0));
      st.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0));
      st.push_back(mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0));
      foreach (st[i]) begin
         @(negedge clk);
         apply(st[i]);
         #1;
         checks++;
         if (cnt_branches !== (PERF_ON ? modelBr : 2'd0) || cnt_mispredicts !== (PERF_ON ? modelMis : 2'd0)) begin
            failures++;
            $display("FAIL perf_counters cyc=%0d got br=%0d mis=%0d exp br=%0d mis=%0d", i,
                     cnt_branches, cnt_mispredicts, PERF_ON ? modelBr : 2'd0, PERF_ON ? modelMis : 2'd0);
         end
         if (sb.size() != 0) begin
            e = sb[0];
            checks++;
            if (out_valid !== 1'b1 || out_taken !== e.taken || out_redirect_pc !== e.redirect ||
                out_mispredict !== e.mispredict) begin
               failures++;
               $display("FAIL perf_result cyc=%0d got v=%0b t=%0b pc=%h mp=%0b exp v=1 t=%0b pc=%h mp=%0b",
                        i, out_valid, out_taken, out_redirect_pc, out_mispredict, e.taken, e.redirect, e.mispredict);
            end
            if (out_ready && !flush) begin
               void'(sb.pop_front());
               if (!e.illegal) begin
                  if (modelBr != 2'd3) modelBr++;
                  if (e.mispredict && modelMis != 2'd3) modelMis++;
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(model(st[i]));
      end
      checks++;
      if (cnt_mispredicts !== (PERF_ON ? 2'd3 : 2'd0) || cnt_branches !== (PERF_ON ? 2'd3 : 2'd0)) begin
         failures++;
         $display("FAIL perf_saturate got br=%0d mis=%0d exp br=%0d mis=%0d",
                  cnt_branches, cnt_mispredicts, PERF_ON ? 3 : 0, PERF_ON ? 3 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_perf_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
